// File: rtl/vdp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vdp_pkg
// Purpose  : Shared definitions for the VDP register-write path: register
//            address/data widths, register index constants and the grant
//            state encoding used by vdp_reg_arbiter.
// Contents : c_addr_w / c_data_w  - register address / data widths
//            c_reg_*              - VDP register indices
//            arb_state_t          - grant FSM state encoding
// Revision : 1.0 - initial release
// ============================================================================
package vdp_pkg;

    localparam int c_addr_w = 6;
    localparam int c_data_w = 16;

    // VDP register indices
    localparam logic [c_addr_w-1:0] c_reg_mode       = 6'h00;
    localparam logic [c_addr_w-1:0] c_reg_irq_ctrl   = 6'h01;
    localparam logic [c_addr_w-1:0] c_reg_bg_color   = 6'h02;
    localparam logic [c_addr_w-1:0] c_reg_scroll_x   = 6'h04;
    localparam logic [c_addr_w-1:0] c_reg_scroll_y   = 6'h05;
    localparam logic [c_addr_w-1:0] c_reg_palette    = 6'h10;
    localparam logic [c_addr_w-1:0] c_reg_sprite_ptr = 6'h20;
    localparam logic [c_addr_w-1:0] c_reg_copper_ctl = 6'h3F;

    // Grant FSM: IDLE = nothing presented, PRESENT = write valid, awaiting accept
    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_PRESENT = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/vdp_reg_write_slot.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vdp_reg_write_slot
// Purpose  : One-entry skid buffer holding a single pending register write
//            from one source. Ready stays high while the entry is being
//            granted so a source can stream back-to-back without bubbles.
// Ports    : clk, reset                 - clock, async active-high reset
//            i_write_en/address/data    - source request
//            o_write_ready              - slot can take a write this cycle
//            o_valid/o_address/o_data   - held entry toward the arbiter
//            i_grant                    - arbiter consumes the entry this cycle
// Revision : 1.0 - initial release
// ============================================================================
module vdp_reg_write_slot
    import vdp_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_write_en,
    input  logic [c_addr_w-1:0] i_write_address,
    input  logic [c_data_w-1:0] i_write_data,
    output logic                o_write_ready,
    output logic                o_valid,
    output logic [c_addr_w-1:0] o_address,
    output logic [c_data_w-1:0] o_data,
    input  logic                i_grant
);

    logic                r_valid;
    logic [c_addr_w-1:0] r_address;
    logic [c_data_w-1:0] r_data;
    logic                w_capture;

    // Arbiter only grants a valid entry, so a grant always frees the slot.
    assign o_write_ready = !r_valid || i_grant;
    assign w_capture     = i_write_en && o_write_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_address <= '0;
            r_data    <= '0;
        end else begin
            if (w_capture) begin
                // Capture wins over grant: the old entry leaves, the new one lands.
                r_valid   <= 1'b1;
                r_address <= i_write_address;
                r_data    <= i_write_data;
            end else if (i_grant) begin
                r_valid   <= 1'b0;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_address = r_address;
    assign o_data    = r_data;

endmodule
`default_nettype wire

// File: rtl/vdp_reg_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vdp_reg_arbiter
// Purpose  : Merges host and copper register writes into a single registered
//            write port toward the VDP register file. Copper has priority,
//            but after HOST_STARVE_LIMIT consecutive copper grants with a host
//            write waiting, the host is granted once.
// Ports    : clk, reset                         - clock, async active-high reset
//            host_write_en/address/data/ready   - host request + backpressure
//            copper_write_en/address/data/ready - copper request + backpressure
//            reg_write_en/address/data          - registered output write
//            reg_write_accept                   - register file consumes output
//            grant_is_host                      - presented write came from host
// Revision : 1.0 - initial release
// ============================================================================
module vdp_reg_arbiter
    import vdp_pkg::*;
#(
    parameter int HOST_STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                host_write_en,
    input  logic [c_addr_w-1:0] host_write_address,
    input  logic [c_data_w-1:0] host_write_data,
    output logic                host_write_ready,
    input  logic                copper_write_en,
    input  logic [c_addr_w-1:0] copper_write_address,
    input  logic [c_data_w-1:0] copper_write_data,
    output logic                copper_write_ready,
    output logic                reg_write_en,
    output logic [c_addr_w-1:0] reg_write_address,
    output logic [c_data_w-1:0] reg_write_data,
    input  logic                reg_write_accept,
    output logic                grant_is_host
);

    // The streak counter is 3 bits wide; clamp the limit into that range.
    localparam int         c_limit_sat    = (HOST_STARVE_LIMIT > 7) ? 7 :
                                            ((HOST_STARVE_LIMIT < 0) ? 0 : HOST_STARVE_LIMIT);
    localparam logic [2:0] c_streak_limit = 3'(c_limit_sat);

    arb_state_t          r_state;
    logic [c_addr_w-1:0] r_address;
    logic [c_data_w-1:0] r_data;
    logic                r_is_host;
    logic [2:0]          r_copper_streak;

    logic                w_host_valid;
    logic [c_addr_w-1:0] w_host_address;
    logic [c_data_w-1:0] w_host_data;
    logic                w_copper_valid;
    logic [c_addr_w-1:0] w_copper_address;
    logic [c_data_w-1:0] w_copper_data;

    logic                w_load;
    logic                w_pick_host;
    logic                w_grant_host;
    logic                w_grant_copper;
    logic                w_grant_any;
    logic [c_addr_w-1:0] w_sel_address;
    logic [c_data_w-1:0] w_sel_data;

    vdp_reg_write_slot u_host_slot (
        .clk             (clk),
        .reset           (reset),
        .i_write_en      (host_write_en),
        .i_write_address (host_write_address),
        .i_write_data    (host_write_data),
        .o_write_ready   (host_write_ready),
        .o_valid         (w_host_valid),
        .o_address       (w_host_address),
        .o_data          (w_host_data),
        .i_grant         (w_grant_host)
    );

    vdp_reg_write_slot u_copper_slot (
        .clk             (clk),
        .reset           (reset),
        .i_write_en      (copper_write_en),
        .i_write_address (copper_write_address),
        .i_write_data    (copper_write_data),
        .o_write_ready   (copper_write_ready),
        .o_valid         (w_copper_valid),
        .o_address       (w_copper_address),
        .o_data          (w_copper_data),
        .i_grant         (w_grant_copper)
    );

    // Output register can take a new write when empty or when the current
    // one is being consumed; otherwise grants stall and slots backpressure.
    assign w_load         = (r_state == ARB_IDLE) || reg_write_accept;

    // Host goes first only when copper is absent or copper has used up its streak.
    assign w_pick_host    = w_host_valid &&
                            (!w_copper_valid || (r_copper_streak == c_streak_limit));
    assign w_grant_host   = w_load && w_pick_host;
    assign w_grant_copper = w_load && w_copper_valid && !w_pick_host;
    assign w_grant_any    = w_grant_host || w_grant_copper;

    assign w_sel_address  = w_pick_host ? w_host_address : w_copper_address;
    assign w_sel_data     = w_pick_host ? w_host_data    : w_copper_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ARB_IDLE;
            r_address       <= '0;
            r_data          <= '0;
            r_is_host       <= 1'b0;
            r_copper_streak <= '0;
        end else begin
            // Streak only measures copper grants that overtook a waiting host.
            if (!w_host_valid || w_grant_host) begin
                r_copper_streak <= '0;
            end else if (w_grant_copper && (r_copper_streak != c_streak_limit)) begin
                r_copper_streak <= r_copper_streak + 3'd1;
            end

            case (r_state)
                ARB_IDLE: begin
                    if (w_grant_any) begin
                        r_state   <= ARB_PRESENT;
                        r_address <= w_sel_address;
                        r_data    <= w_sel_data;
                        r_is_host <= w_grant_host;
                    end
                end
                ARB_PRESENT: begin
                    if (reg_write_accept) begin
                        if (w_grant_any) begin
                            r_address <= w_sel_address;
                            r_data    <= w_sel_data;
                            r_is_host <= w_grant_host;
                        end else begin
                            r_state   <= ARB_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign reg_write_en      = (r_state == ARB_PRESENT);
    assign reg_write_address = r_address;
    assign reg_write_data    = r_data;
    assign grant_is_host     = r_is_host;

endmodule
`default_nettype wire
